// File: rtl/mem_responder.sv
// Unified instruction/data memory with a programmable response delay and a one-cycle MemReady pulse.
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned accesses on MemErr and suppress their effect.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        count;
    logic [7:0]        count_next;
    logic              accept;
    logic              enter_resp;

    logic [IDX_W-1:0]  index_q;
    logic [31:0]       wdata_q;
    logic              read_q;
    logic              write_q;
    logic              trap;
    logic              misaligned;

    logic [31:0]       mem [DEPTH_WORDS];

    // Address bits above the index are dropped so accesses wrap modulo DEPTH_WORDS*4.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr[31:IDX_W+2], Addr[1:0]};

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (Addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // WAIT is always entered after accept and left once the counter reaches zero,
    // giving WAIT_CYCLES+1 cycles between the accept edge and the RESP-entry edge.
    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    accept     = 1'b1;
                    count_next = 8'(WAIT_CYCLES);
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (count == 8'd0) begin
                    enter_resp = 1'b1;
                    state_next = S_RESP;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            trap    <= 1'b0;
        end else if (accept) begin
            index_q <= Addr[IDX_W+1:2];
            wdata_q <= WriteData;
            read_q  <= MemRead;
            write_q <= MemWrite;
            trap    <= misaligned;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadData <= '0;
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
        end else begin
            MemReady <= enter_resp;
            MemErr   <= enter_resp && trap;
            if (enter_resp) begin
                if (trap) begin
                    ReadData <= '0;
                end else if (read_q) begin
                    ReadData <= mem[index_q];
                end
            end
        end
    end

    // Memory contents survive reset; a write only lands on the RESP-entry edge.
    always_ff @(posedge clk) begin
        if (enter_resp && write_q && !trap) begin
            mem[index_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (WAIT_CYCLES 0 and 3) share one request stream.
// Expected values follow MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] rdata0;
    logic [31:0] rdata3;
    logic        ready0;
    logic        ready3;
    logic        err0;
    logic        err3;

    int n_cmp;
    int n_err;

    int          r0_cyc;
    int          r3_cyc;
    int          p0;
    int          p3;
    logic [31:0] rd0;
    logic [31:0] rd3;
    logic        e0;
    logic        e3;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (rdata0),
        .MemReady  (ready0),
        .MemErr    (err0)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (rdata3),
        .MemReady  (ready3),
        .MemErr    (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: strobes held for a single edge, then address/data scrambled to show they are ignored.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit do_reset);
        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        Addr      = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Addr      = 32'h0000_0044;
        WriteData = $urandom;
        r0_cyc = 0;
        r3_cyc = 0;
        p0 = 0;
        p3 = 0;
        rd0 = 'x;
        rd3 = 'x;
        e0 = 1'bx;
        e3 = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ready0) begin
                p0++;
                if (r0_cyc == 0) begin
                    r0_cyc = c;
                    rd0 = rdata0;
                    e0 = err0;
                end
            end
            if (ready3) begin
                p3++;
                if (r3_cyc == 0) begin
                    r3_cyc = c;
                    rd3 = rdata3;
                    e3 = err3;
                end
            end
            if (do_reset && c == 1) reset = 1'b1;
            if (do_reset && c == 3) reset = 1'b0;
        end
    endtask

    task automatic expect_done(input string tag, input logic [31:0] exp_rd, input logic exp_err);
        check({tag, " ready cycle w0"}, 32'(r0_cyc), 32'd2);
        check({tag, " ready cycle w3"}, 32'(r3_cyc), 32'd5);
        check({tag, " pulses w0"}, 32'(p0), 32'd1);
        check({tag, " pulses w3"}, 32'(p3), 32'd1);
        check({tag, " rdata w0"}, rd0, exp_rd);
        check({tag, " rdata w3"}, rd3, exp_rd);
        check({tag, " err w0"}, {31'd0, e0}, {31'd0, exp_err});
        check({tag, " err w3"}, {31'd0, e3}, {31'd0, exp_err});
        check({tag, " rdata held w0"}, rdata0, exp_rd);
        check({tag, " rdata held w3"}, rdata3, exp_rd);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
        repeat (2) @(negedge clk);
        check("reset rdata w0", rdata0, 32'h0);
        check("reset rdata w3", rdata3, 32'h0);
        check("reset ready w0", {31'd0, ready0}, 32'd0);
        check("reset ready w3", {31'd0, ready3}, 32'd0);
        check("reset err w0", {31'd0, err0}, 32'd0);
        check("reset err w3", {31'd0, err3}, 32'd0);
        reset = 1'b0;

        access(1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1'b0);
        expect_done("preload 0x40", 32'h0, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1);
        check("abort pulses w0", 32'(p0), 32'd0);
        check("abort pulses w3", 32'(p3), 32'd0);
        check("abort rdata w3", rdata3, 32'h0);

        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        expect_done("read 0x40 after abort", 32'h0BAD_F00D, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0);
        expect_done("write 0x10", 32'h0BAD_F00D, 1'b0);

        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        expect_done("read 0x10", 32'hCAFE_F00D, 1'b0);

        access(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
        expect_done("swap 0x10", 32'hCAFE_F00D, 1'b0);

        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        expect_done("read 0x10 after swap", 32'h1234_5678, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 1'b0);
        expect_done("write 0x400", 32'h1234_5678, 1'b0);

        access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
        expect_done("read 0x0 wrap", 32'hA5A5_A5A5, 1'b0);

        access(1'b0, 1'b1, 32'h0000_0020, 32'h2020_2020, 1'b0);
        expect_done("write 0x20", 32'hA5A5_A5A5, 1'b0);

`ifdef MISALIGN_TRAP_EN
        access(1'b0, 1'b1, 32'h0000_0022, 32'h1111_1111, 1'b0);
        expect_done("misaligned write 0x22", 32'h0, 1'b1);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        expect_done("read 0x20 after trap", 32'h2020_2020, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0023, 32'h0, 1'b0);
        expect_done("misaligned read 0x23", 32'h0, 1'b1);
`else
        access(1'b0, 1'b1, 32'h0000_0022, 32'h1111_1111, 1'b0);
        expect_done("unaligned write 0x22", 32'hA5A5_A5A5, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        expect_done("read 0x20 after unaligned", 32'h1111_1111, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0023, 32'h0, 1'b0);
        expect_done("unaligned read 0x23", 32'h1111_1111, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
